// File: rtl/regfile_scoreboard_if.sv
// Operand-fetch bus of the register file: two read ports, one reserve port and one writeback port.
// The master drives the requests and the slave returns the registered responses.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   localparam int NREGS = 2 ** ADDR_W;

   logic              rd0_en;
   logic [ADDR_W-1:0] rd0_addr;
   logic              rd1_en;
   logic [ADDR_W-1:0] rd1_addr;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] rd0_data;
   logic [DATA_W-1:0] rd1_data;
   logic              hold_flag;
   logic              rsv_err;
   logic [NREGS-1:0]  busy_mask;

   modport master (
      output rd0_en, rd0_addr, rd1_en, rd1_addr, rsv_en, rsv_addr, wb_en, wb_addr, wb_data,
      input  rd0_data, rd1_data, hold_flag, rsv_err, busy_mask
   );

   modport slave (
      input  rd0_en, rd0_addr, rd1_en, rd1_addr, rsv_en, rsv_addr, wb_en, wb_addr, wb_data,
      output rd0_data, rd1_data, hold_flag, rsv_err, busy_mask
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending (hold) scoreboard for the NewLondo16 operand-fetch stage.
// Two registered read ports with writeback bypass, one writeback port, one reserve port.
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 EN,
   regfile_scoreboard_if.slave  bus
);
   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREGS];
   logic [NREGS-1:0]  hold;
   logic [NREGS-1:0]  hold_next;
   logic              wb_ok;
   logic              rsv_ok;
   logic              byp0;
   logic              byp1;
   logic              hit0;
   logic              hit1;
   logic              rsv_collide;
   logic [DATA_W-1:0] rd0_val;
   logic [DATA_W-1:0] rd1_val;

   function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      wb_ok       = bus.wb_en  && !is_zero(bus.wb_addr);
      rsv_ok      = bus.rsv_en && !is_zero(bus.rsv_addr);
      byp0        = wb_ok && (bus.wb_addr == bus.rd0_addr);
      byp1        = wb_ok && (bus.wb_addr == bus.rd1_addr);
      rd0_val     = is_zero(bus.rd0_addr) ? '0 : (byp0 ? bus.wb_data : mem[bus.rd0_addr]);
      rd1_val     = is_zero(bus.rd1_addr) ? '0 : (byp1 ? bus.wb_data : mem[bus.rd1_addr]);
      // Pre-edge hold state: a reserve in this same cycle cannot cause a hit.
      hit0        = bus.rd0_en && hold[bus.rd0_addr] && !byp0;
      hit1        = bus.rd1_en && hold[bus.rd1_addr] && !byp1;
      rsv_collide = rsv_ok && hold[bus.rsv_addr] && !(wb_ok && (bus.wb_addr == bus.rsv_addr));
      hold_next   = hold;
      if (wb_ok)  hold_next[bus.wb_addr]  = 1'b0;
      if (rsv_ok) hold_next[bus.rsv_addr] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         // NOTE: the data array is reset here because a cleared register file is architecturally visible.
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
         hold          <= '0;
         bus.rd0_data  <= '0;
         bus.rd1_data  <= '0;
         bus.hold_flag <= 1'b0;
         bus.rsv_err   <= 1'b0;
      end else if (EN) begin
         if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
         hold          <= hold_next;
         if (bus.rd0_en) bus.rd0_data <= rd0_val;
         if (bus.rd1_en) bus.rd1_data <= rd1_val;
         bus.hold_flag <= hit0 || hit1;
         bus.rsv_err   <= rsv_collide;
      end
   end

   assign bus.busy_mask = hold;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (ZERO_REG=1); the driver queues hand-computed responses
// per clock edge and an independent monitor compares them on the following falling edge.
module tb_regfile_scoreboard;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef struct {
      string       name;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        hf;
      logic        err;
      logic [15:0] busy;
   } exp_t;

   logic CLK = 1'b0;
   logic Reset;
   logic EN;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .EN    (EN),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every queued entry corresponds to one rising edge and is checked on the next falling edge.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, ".rd0_data"},  bus.rd0_data,          e.rd0);
         check({e.name, ".rd1_data"},  bus.rd1_data,          e.rd1);
         check({e.name, ".hold_flag"}, {31'd0, bus.hold_flag}, {31'd0, e.hf});
         check({e.name, ".rsv_err"},   {31'd0, bus.rsv_err},   {31'd0, e.err});
         check({e.name, ".busy_mask"}, {16'd0, bus.busy_mask}, {16'd0, e.busy});
      end
   end

   task automatic idle();
      Reset        = 1'b1;
      EN           = 1'b1;
      bus.rd0_en   = 1'b0;
      bus.rd0_addr = '0;
      bus.rd1_en   = 1'b0;
      bus.rd1_addr = '0;
      bus.rsv_en   = 1'b0;
      bus.rsv_addr = '0;
      bus.wb_en    = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
   endtask

   task automatic rd0(input logic [3:0] a);
      bus.rd0_en = 1'b1; bus.rd0_addr = a;
   endtask
   task automatic rd1(input logic [3:0] a);
      bus.rd1_en = 1'b1; bus.rd1_addr = a;
   endtask
   task automatic rsv(input logic [3:0] a);
      bus.rsv_en = 1'b1; bus.rsv_addr = a;
   endtask
   task automatic wb(input logic [3:0] a, input logic [31:0] d);
      bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
   endtask

   // Apply the current inputs across one rising edge and queue the response expected after it.
   task automatic tick(input string name, input logic [31:0] e0, input logic [31:0] e1,
                       input logic ehf, input logic eerr, input logic [15:0] ebusy);
      exp_t e;
      @(posedge CLK);
      e.name = name; e.rd0 = e0; e.rd1 = e1; e.hf = ehf; e.err = eerr; e.busy = ebusy;
      exp_q.push_back(e);
      #1;
   endtask

   initial begin
      idle();
      Reset = 1'b0;
      tick("reset_a", 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
      Reset = 1'b0;
      tick("reset_b", 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);

      idle(); rd0(4'd3); rd1(4'd15);
      tick("rd_after_reset", 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);

      idle(); wb(4'd5, 32'hDEADBEEF); rd0(4'd5);
      tick("wb_bypass", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 16'h0000);
      idle(); rd0(4'd5); rd1(4'd5);
      tick("rd_array_both", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000);

      idle(); rsv(4'd7);
      tick("rsv_r7", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0080);
      idle(); rd1(4'd7);
      tick("stall_r7", 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 16'h0080);
      idle(); wb(4'd7, 32'h12); rd1(4'd7);
      tick("wb_clears_r7", 32'hDEADBEEF, 32'h12, 1'b0, 1'b0, 16'h0000);

      idle(); rsv(4'd2);
      tick("rsv_r2_first", 32'hDEADBEEF, 32'h12, 1'b0, 1'b0, 16'h0004);
      idle(); rsv(4'd2);
      tick("rsv_r2_again", 32'hDEADBEEF, 32'h12, 1'b0, 1'b1, 16'h0004);
      idle();
      tick("rsv_err_drops", 32'hDEADBEEF, 32'h12, 1'b0, 1'b0, 16'h0004);
      idle(); wb(4'd2, 32'hA5A50002); rsv(4'd2);
      tick("wb_rsv_same", 32'hDEADBEEF, 32'h12, 1'b0, 1'b0, 16'h0004);
      idle(); rd0(4'd2);
      tick("rd_r2_pending", 32'hA5A50002, 32'h12, 1'b1, 1'b0, 16'h0004);

      idle(); rsv(4'd3); rd0(4'd3);
      tick("rsv_same_cycle_no_hit", 32'h0, 32'h12, 1'b0, 1'b0, 16'h000C);

      idle(); wb(4'd0, 32'hFFFFFFFF); rsv(4'd0); rd0(4'd0);
      tick("zero_reg_a", 32'h0, 32'h12, 1'b0, 1'b0, 16'h000C);
      idle(); rsv(4'd0); rd0(4'd0); rd1(4'd0);
      tick("zero_reg_b", 32'h0, 32'h0, 1'b0, 1'b0, 16'h000C);

      idle(); wb(4'd3, 32'h33); rd0(4'd3); rd1(4'd2);
      tick("bypass_and_hit", 32'h33, 32'hA5A50002, 1'b1, 1'b0, 16'h0004);
      idle(); wb(4'd2, 32'h22);
      tick("wb_clears_r2", 32'h33, 32'hA5A50002, 1'b0, 1'b0, 16'h0000);

      idle(); rsv(4'd9);
      tick("rsv_r9", 32'h33, 32'hA5A50002, 1'b0, 1'b0, 16'h0200);
      for (int i = 0; i < 3; i++) begin
         idle(); EN = 1'b0; wb(4'd9, 32'h99); rd0(4'd9); rsv(4'd4);
         tick("en_low", 32'h33, 32'hA5A50002, 1'b0, 1'b0, 16'h0200);
      end
      idle(); rd0(4'd9);
      tick("en_back_r9", 32'h0, 32'hA5A50002, 1'b1, 1'b0, 16'h0200);

      idle(); Reset = 1'b0; EN = 1'b0; rsv(4'd6); rd0(4'd5);
      tick("reset_mid", 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);
      idle(); rd0(4'd5);
      tick("rd_after_reset_mid", 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000);

      idle();
      @(negedge CLK);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with a per-register scoreboard, for the NewLondo16 operand-fetch stage. It provides two registered read ports and one writeback port, plus a reserve port that marks a destination register as pending while its result is in flight. A fetch that hits a pending register raises a registered hold flag, so the following pipeline slot becomes a no-op. Register-to-register bypass on writeback and an optional hardwired zero register are included.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers
- ZERO_REG, 0, when 1: register 0 always reads 0, ignores writes, is never held
- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  reset is synchronous and active-low (sampled on the rising CLK edge)
- EN  in  1  global enable; when low, no state changes and all outputs hold
- rd0_en, rd1_en  in  1  read-port request
- rd0_addr, rd1_addr  in  ADDR_W  read-port register index
- rsv_en  in  1  reserve request: mark rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- wb_en  in  1  writeback request
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- rd0_data, rd1_data  out  DATA_W  registered read data
- hold_flag  out  1  registered; 1 means the last accepted fetch hit a pending register
- rsv_err  out  1  registered one-cycle pulse: reserve targeted an already-pending register
- busy_mask  out  NREGS  current hold bits; bit i corresponds to register i

## Operation
- State: NREGS x DATA_W data array and NREGS hold bits.
- Reset (Reset=0 at a rising edge):
  - all data registers and hold bits cleared
  - rd0_data = rd1_data = 0, hold_flag = 0, rsv_err = 0, busy_mask = 0
  - Reset overrides EN.
- The rules below apply only when EN=1.
- Writeback: wb_en=1 writes wb_data to wb_addr and clears hold[wb_addr].
- Reserve: rsv_en=1 sets hold[rsv_addr].
  - If hold[rsv_addr] was already 1 and the same cycle has no wb to that address, rsv_err=1 next cycle; the hold stays 1.
  - rsv_err is 0 in every other cycle.
- Read port n, rdn_en=1: rdn_data <= value of rdn_addr.
  - Bypass: if wb_en=1 and wb_addr==rdn_addr, the value is wb_data.
  - Otherwise the value is the array contents.
  - rdn_en=0: rdn_data holds its previous value.
- hold_flag <= OR over enabled ports of hit_n, where hit_n = hold[rdn_addr] AND NOT (wb_en AND wb_addr==rdn_addr).
  - The pre-edge hold state is used; a reserve issued in the same cycle does not cause a hit.
  - hold_flag is recomputed every EN=1 cycle and drops to 0 when no enabled port hits.
- Read data updates even when hold_flag is set; the consumer discards it.
- Simultaneous wb and rsv to the same address: data is written and the hold ends at 1 (reserve wins). No rsv_err is raised.
- ZERO_REG=1 with address 0:
  - reads return 0, with no bypass
  - writes are dropped
  - rsv is ignored: no hold and no rsv_err
  - hit is never set
- Both read ports may target the same register; each gets an identical result.

## Timing
- Read latency: 1 cycle. Address is sampled at edge k; data is valid after edge k.
- Write-to-read: a read in the same cycle as the wb gets the new value via bypass. Reads in later cycles get it from the array.
- Reserve-to-hit: a reserve at edge k makes a read at edge k+1 or later set hold_flag.
- hold_flag and rsv_err are valid one cycle after the triggering request.
- busy_mask reflects the hold bits updated at the last edge; it is not registered separately.
- EN=0 mid-operation: pending holds persist and no request is lost or duplicated; requests presented while EN=0 are ignored.
- Reset asserted mid-operation: all pending holds are discarded on the next edge.

## Test plan
- Reset then read: Reset=0 for 2 cycles, then rd0 r3 and rd1 r15 -> both data 0, hold_flag 0, busy_mask 0.
- Write/read with bypass: wb r5=0xDEADBEEF and rd0 r5 in the same cycle -> rd0_data 0xDEADBEEF next cycle. The next read of r5 returns the same value from the array.
- Scoreboard stall: rsv r7, next cycle rd1 r7 -> hold_flag 1, busy_mask[7]=1. Then wb r7=0x12 with rd1 r7 in the same cycle -> hold_flag 0, rd1_data 0x12, busy_mask[7]=0.
- Reserve collisions:
  - rsv r2 twice on consecutive cycles -> rsv_err pulses 1 for exactly one cycle; hold[2] stays 1.
  - wb r2 plus rsv r2 in the same cycle -> rsv_err 0, data written, hold[2]=1.
- ZERO_REG=1: wb r0=0xFFFF_FFFF, rsv r0, rd0 r0 -> rd0_data 0, busy_mask[0]=0, hold_flag 0, rsv_err 0.
- EN and reset mid-flight:
  - rsv r9, then EN=0 for 3 cycles with wb r9 presented -> busy_mask[9] stays 1 and the data is unchanged.
  - Then Reset=0 for one cycle -> busy_mask 0 and all outputs 0.
